// File: rtl/audio_pkg.sv
// Shared audio types and I2S rate constants for the 32 MHz core clock domain.
package audio_pkg;

    typedef logic signed [15:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } stereo_t;

    localparam int I2S_FRAME_BITS  = 32;
    localparam int I2S_DIV_NUM_32M = 12;
    localparam int I2S_DIV_DEN_32M = 125;

    // Philips framing: word select flips one BCLK ahead of each channel MSB.
    function automatic logic philips_lrck(input logic [4:0] bit_cnt);
        return (bit_cnt >= 5'd15) && (bit_cnt <= 5'd30);
    endfunction

endpackage

// File: rtl/i2s_tx_sequencer_if.sv
// Sample-pair valid/ready stream from the audio source into the I2S sequencer.
interface i2s_tx_sequencer_if;
    import audio_pkg::*;

    logic    s_valid;
    logic    s_ready;
    sample_t s_left;
    sample_t s_right;

    modport master (output s_valid, output s_left, output s_right, input s_ready);
    modport slave  (input s_valid, input s_left, input s_right, output s_ready);

endinterface

// File: rtl/frac_tick_gen.sv
// Fractional rate generator: tick rate = clk32 * NUM / DEN with no long-term drift.
module frac_tick_gen #(
    parameter int NUM = 12,
    parameter int DEN = 125
) (
    input  logic clk32,
    input  logic reset_n,
    input  logic en,
    output logic tick
);

    // acc stays below DEN, so acc + NUM always fits in clog2(DEN + NUM) bits.
    localparam int ACC_W = $clog2(DEN + NUM);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;

    always_comb begin
        sum   = acc_q + ACC_W'(NUM);
        tick  = 1'b0;
        acc_d = '0;
        if (en) begin
            if (sum >= ACC_W'(DEN)) begin
                tick  = 1'b1;
                acc_d = sum - ACC_W'(DEN);
            end else begin
                acc_d = sum;
            end
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/i2s_tx_sequencer.sv
// I2S DAC transmitter: fractional BCLK, 32-bit stereo framing, one-entry sample
// holding buffer with sticky underrun flag.
module i2s_tx_sequencer
    import audio_pkg::*;
#(
    parameter int DIV_NUM    = I2S_DIV_NUM_32M,
    parameter int DIV_DEN    = I2S_DIV_DEN_32M,
    parameter bit PHILIPS    = 1'b1,
    parameter bit UNDER_HOLD = 1'b1
) (
    input  logic              clk32,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mute,
    input  logic              underrun_clr,
    i2s_tx_sequencer_if.slave src,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_din,
    output logic              frame_strobe,
    output logic              underrun
);

    logic tick;
    logic fall;
    logic load;
    logic accept;

    logic [4:0] bit_cnt_q;
    logic [4:0] bit_cnt_d;
    logic [4:0] bit_cnt_inc;

    logic bclk_q,      bclk_d;
    logic lrck_q,      lrck_d;
    logic strobe_q,    strobe_d;
    logic underrun_q,  underrun_d;
    logic hold_full_q, hold_full_d;

    logic [I2S_FRAME_BITS-1:0] shreg_q;
    logic [I2S_FRAME_BITS-1:0] shreg_d;
    logic [I2S_FRAME_BITS-1:0] load_word;

    stereo_t hold_q, hold_d;
    stereo_t last_q, last_d;

    frac_tick_gen #(
        .NUM (DIV_NUM),
        .DEN (DIV_DEN)
    ) u_tick (
        .clk32   (clk32),
        .reset_n (reset_n),
        .en      (enable),
        .tick    (tick)
    );

    assign fall        = tick & bclk_q;
    assign bit_cnt_inc = bit_cnt_q + 5'd1;
    assign load        = fall && (bit_cnt_q == 5'd31);
    assign accept      = src.s_valid && !hold_full_q;

    // An empty hold at load time is an underrun; last is replayed only when unmuted.
    always_comb begin
        if (hold_full_q) begin
            load_word = mute ? '0 : hold_q;
        end else if (UNDER_HOLD && !mute) begin
            load_word = last_q;
        end else begin
            load_word = '0;
        end
    end

    always_comb begin
        bclk_d      = bclk_q;
        lrck_d      = lrck_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        last_d      = last_q;
        hold_full_d = hold_full_q;
        strobe_d    = load;
        underrun_d  = underrun_q;

        if (!enable) begin
            bclk_d    = 1'b0;
            lrck_d    = 1'b0;
            bit_cnt_d = 5'd31;
            shreg_d   = '0;
        end else if (tick) begin
            bclk_d = ~bclk_q;
            if (fall) begin
                bit_cnt_d = bit_cnt_inc;
                lrck_d    = PHILIPS ? philips_lrck(bit_cnt_inc) : bit_cnt_inc[4];
                shreg_d   = load ? load_word : (shreg_q << 1);
            end
        end

        if (load && hold_full_q) begin
            last_d      = hold_q;
            hold_full_d = 1'b0;
        end

        // s_ready is low while full, so an accept never collides with a consuming load.
        if (accept) begin
            hold_full_d = 1'b1;
            hold_d      = {src.s_left, src.s_right};
        end

        if (load && !hold_full_q) begin
            underrun_d = 1'b1;
        end else if (underrun_clr) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk32 or negedge reset_n) begin
        if (!reset_n) begin
            bclk_q      <= 1'b0;
            lrck_q      <= 1'b0;
            bit_cnt_q   <= 5'd31;
            shreg_q     <= '0;
            hold_q      <= '0;
            last_q      <= '0;
            hold_full_q <= 1'b0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            last_q      <= last_d;
            hold_full_q <= hold_full_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    assign src.s_ready  = !hold_full_q;
    assign i2s_bclk     = bclk_q;
    assign i2s_lrck     = lrck_q;
    assign i2s_din      = shreg_q[I2S_FRAME_BITS-1];
    assign frame_strobe = strobe_q;
    assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_sequencer.sv
// Bench for i2s_tx_sequencer: two instances (Philips/hold-last and left-justified/zero-fill)
// share stimulus and are checked each cycle against a frame-level reference model.
module tb_i2s_tx_sequencer;
    import audio_pkg::*;

    localparam int NUM = I2S_DIV_NUM_32M;
    localparam int DEN = I2S_DIV_DEN_32M;

    logic        clk32 = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mute;
    logic        underrun_clr;
    logic        src_valid;
    logic [15:0] src_l;
    logic [15:0] src_r;

    logic bclk_a, lrck_a, din_a, fs_a, und_a;
    logic bclk_b, lrck_b, din_b, fs_b, und_b;

    i2s_tx_sequencer_if if_a ();
    i2s_tx_sequencer_if if_b ();

    assign if_a.s_valid = src_valid;
    assign if_a.s_left  = src_l;
    assign if_a.s_right = src_r;
    assign if_b.s_valid = src_valid;
    assign if_b.s_left  = src_l;
    assign if_b.s_right = src_r;

    i2s_tx_sequencer #(.DIV_NUM(NUM), .DIV_DEN(DEN), .PHILIPS(1'b1), .UNDER_HOLD(1'b1)) dut_a (
        .clk32(clk32), .reset_n(reset_n), .enable(enable), .mute(mute),
        .underrun_clr(underrun_clr), .src(if_a),
        .i2s_bclk(bclk_a), .i2s_lrck(lrck_a), .i2s_din(din_a),
        .frame_strobe(fs_a), .underrun(und_a)
    );

    i2s_tx_sequencer #(.DIV_NUM(NUM), .DIV_DEN(DEN), .PHILIPS(1'b0), .UNDER_HOLD(1'b0)) dut_b (
        .clk32(clk32), .reset_n(reset_n), .enable(enable), .mute(mute),
        .underrun_clr(underrun_clr), .src(if_b),
        .i2s_bclk(bclk_b), .i2s_lrck(lrck_b), .i2s_din(din_b),
        .frame_strobe(fs_b), .underrun(und_b)
    );

    always #5 clk32 = ~clk32;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    // reference model state: enabled-cycle count, holding buffer, frame words
    int          m_n;
    logic        m_full;
    logic        m_und;
    logic        m_strobe;
    logic [31:0] m_hold;
    logic [31:0] m_last;
    logic [31:0] m_cur_a;
    logic [31:0] m_cur_b;

    int          cap_cnt;
    logic [31:0] cap_a;
    logic [31:0] cap_b;
    logic        prev_bclk;

    typedef struct {
        bit          give;
        logic [31:0] data;
        bit          mute;
        bit          clr;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        bit          exp_und;
    } frame_vec_t;

    frame_vec_t tbl[6];

    // BCLK edges after n enabled cycles, straight from the rate definition
    function automatic int ticks_at(input int n);
        return (n * NUM) / DEN;
    endfunction

    // frame loads sit on the 2nd, 66th, 130th ... tick after enable
    function automatic bit load_at(input int n);
        if (n < 1) return 1'b0;
        return (ticks_at(n) != ticks_at(n - 1)) && ((ticks_at(n) % 64) == 2);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        vec_cnt++;
        miss_cnt++;
        $display("FAIL %s: wait bound expired at t=%0t", name, $time);
    endtask

    task automatic model_reset();
        m_n      = 0;
        m_full   = 1'b0;
        m_und    = 1'b0;
        m_strobe = 1'b0;
        m_hold   = '0;
        m_last   = '0;
        m_cur_a  = '0;
        m_cur_b  = '0;
    endtask

    task automatic model_edge();
        logic acc, ld, was_full;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc      = src_valid && !m_full;
        was_full = m_full;
        if (enable) begin
            m_n++;
            ld = load_at(m_n);
        end else begin
            m_n = 0;
            ld  = 1'b0;
        end
        if (ld) begin
            if (was_full) begin
                m_cur_a = mute ? 32'h0 : m_hold;
                m_cur_b = m_cur_a;
                m_last  = m_hold;
                m_full  = 1'b0;
            end else begin
                m_cur_a = mute ? 32'h0 : m_last;
                m_cur_b = 32'h0;
            end
        end
        if (ld && !was_full) m_und = 1'b1;
        else if (underrun_clr) m_und = 1'b0;
        if (acc) begin
            m_full = 1'b1;
            m_hold = {src_l, src_r};
        end
        m_strobe = ld;
    endtask

    task automatic check_outputs();
        int   t, f, b;
        logic e_din_a, e_din_b, e_lr_a, e_lr_b;
        t = ticks_at(m_n);
        f = t / 2;
        if (f == 0) begin
            e_din_a = 1'b0; e_din_b = 1'b0; e_lr_a = 1'b0; e_lr_b = 1'b0;
        end else begin
            b       = (f - 1) % 32;
            e_din_a = m_cur_a[31 - b];
            e_din_b = m_cur_b[31 - b];
            e_lr_a  = (b >= 15) && (b <= 30);
            e_lr_b  = ((b / 16) % 2) == 1;
        end
        chk("bclk_a",   32'(bclk_a),       32'(t % 2));
        chk("bclk_b",   32'(bclk_b),       32'(t % 2));
        chk("lrck_a",   32'(lrck_a),       32'(e_lr_a));
        chk("lrck_b",   32'(lrck_b),       32'(e_lr_b));
        chk("din_a",    32'(din_a),        32'(e_din_a));
        chk("din_b",    32'(din_b),        32'(e_din_b));
        chk("strobe_a", 32'(fs_a),         32'(m_strobe));
        chk("strobe_b", 32'(fs_b),         32'(m_strobe));
        chk("under_a",  32'(und_a),        32'(m_und));
        chk("under_b",  32'(und_b),        32'(m_und));
        chk("ready_a",  32'(if_a.s_ready), 32'(!m_full));
        chk("ready_b",  32'(if_b.s_ready), 32'(!m_full));
    endtask

    task automatic cycle();
        @(posedge clk32);
        model_edge();
        @(negedge clk32);
        check_outputs();
        if (fs_a) begin
            cap_cnt = 0;
        end else if (bclk_a && !prev_bclk) begin
            cap_a = {cap_a[30:0], din_a};
            cap_b = {cap_b[30:0], din_b};
            cap_cnt++;
        end
        prev_bclk = bclk_a;
    endtask

    task automatic offer(input logic [31:0] d);
        bit got;
        got       = 1'b0;
        src_valid = 1'b1;
        src_l     = d[31:16];
        src_r     = d[15:0];
        for (int k = 0; k < 1500 && !got; k++) begin
            got = if_a.s_ready;
            cycle();
        end
        if (!got) expire("accept wait");
        src_valid = 1'b0;
    endtask

    // next frame as shifted out: the 32 BCLK rises following a frame strobe
    task automatic run_frame(output logic [31:0] wa, output logic [31:0] wb);
        bit seen;
        seen = 1'b0;
        wa   = '0;
        wb   = '0;
        for (int k = 0; k < 1500 && !seen; k++) begin
            cycle();
            if (fs_a) seen = 1'b1;
        end
        if (!seen) begin
            expire("frame strobe wait");
            return;
        end
        for (int k = 0; k < 800 && cap_cnt < 32; k++) cycle();
        if (cap_cnt < 32) expire("frame bits wait");
        wa = cap_a;
        wb = cap_b;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          toggles, last_t, gmin, gmax, acc_cnt, strobes, off_cnt;
        logic        pb, acc;
        logic [31:0] wa, wb;

        tbl[0] = '{1'b1, 32'h8001_7FFE, 1'b0, 1'b0, 32'h8001_7FFE, 32'h8001_7FFE, 1'b0};
        tbl[1] = '{1'b1, 32'h1234_ABCD, 1'b0, 1'b0, 32'h1234_ABCD, 32'h1234_ABCD, 1'b0};
        tbl[2] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h1234_ABCD, 32'h0000_0000, 1'b1};
        tbl[3] = '{1'b1, 32'h0F0F_F0F0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        tbl[4] = '{1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0F0F_F0F0, 32'h0000_0000, 1'b1};
        tbl[5] = '{1'b1, 32'h5555_AAAA, 1'b0, 1'b0, 32'h5555_AAAA, 32'h5555_AAAA, 1'b0};

        reset_n      = 1'b1;
        enable       = 1'b0;
        mute         = 1'b0;
        underrun_clr = 1'b0;
        src_valid    = 1'b0;
        src_l        = '0;
        src_r        = '0;
        cap_cnt      = 0;
        cap_a        = '0;
        cap_b        = '0;
        prev_bclk    = 1'b0;
        model_reset();
        #2 reset_n = 1'b0;
        repeat (3) cycle();
        chk("reset bclk",  32'(bclk_a),       32'h0);
        chk("reset lrck",  32'(lrck_a),       32'h0);
        chk("reset din",   32'(din_a),        32'h0);
        chk("reset ready", 32'(if_a.s_ready), 32'h1);
        chk("reset under", 32'(und_b),        32'h0);
        reset_n = 1'b1;
        cycle();

        // rate: 10000 enabled cycles give exactly 960 BCLK edges, 10 or 11 cycles apart
        enable  = 1'b1;
        toggles = 0; last_t = 0; gmin = 1000; gmax = 0;
        pb      = bclk_a;
        for (int i = 1; i <= 10000; i++) begin
            cycle();
            if (bclk_a != pb) begin
                toggles++;
                if (last_t > 0) begin
                    if (i - last_t < gmin) gmin = i - last_t;
                    if (i - last_t > gmax) gmax = i - last_t;
                end
                last_t = i;
                pb     = bclk_a;
            end
        end
        chk("tick count", 32'(toggles), 32'd960);
        chk("phase min",  32'(gmin),    32'd10);
        chk("phase max",  32'(gmax),    32'd11);

        enable       = 1'b0;
        underrun_clr = 1'b1;
        cycle();
        underrun_clr = 1'b0;
        cycle();
        enable = 1'b1;

        // frame table: content, underrun repeat/zero fill, mute
        foreach (tbl[i]) begin
            mute = tbl[i].mute;
            if (tbl[i].give) offer(tbl[i].data);
            run_frame(wa, wb);
            mute = 1'b0;
            chk($sformatf("frame %0d philips", i), wa, tbl[i].exp_a);
            chk($sformatf("frame %0d leftjust", i), wb, tbl[i].exp_b);
            chk($sformatf("frame %0d underrun", i), 32'(und_a), 32'(tbl[i].exp_und));
            if (tbl[i].clr) begin
                underrun_clr = 1'b1;
                cycle();
                underrun_clr = 1'b0;
                chk($sformatf("frame %0d clr", i), 32'(und_a), 32'h0);
            end
        end

        // accept on the very edge of a load that finds hold empty
        underrun_clr = 1'b1;
        cycle();
        underrun_clr = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int k = 0; k < 1500 && !hit; k++) begin
                if (load_at(m_n + 1)) begin
                    src_valid = 1'b1;
                    src_l     = 16'hCAFE;
                    src_r     = 16'hBEEF;
                    cycle();
                    src_valid = 1'b0;
                    hit       = 1'b1;
                end else begin
                    cycle();
                end
            end
            if (!hit) expire("coincident load wait");
        end
        chk("coinc strobe",   32'(fs_a),         32'h1);
        chk("coinc underrun", 32'(und_a),        32'h1);
        chk("coinc ready",    32'(if_a.s_ready), 32'h0);
        run_frame(wa, wb);
        chk("coinc next a", wa, 32'hCAFE_BEEF);
        chk("coinc next b", wb, 32'hCAFE_BEEF);

        // s_valid held high: one accept per frame
        src_valid = 1'b1;
        src_l     = 16'($urandom);
        src_r     = 16'($urandom);
        acc_cnt   = 0;
        strobes   = 0;
        for (int k = 0; k < 4000 && strobes < 4; k++) begin
            acc = src_valid && if_a.s_ready;
            cycle();
            if (acc) begin
                acc_cnt++;
                src_l = 16'($urandom);
                src_r = 16'($urandom);
            end
            if (fs_a) begin
                if (strobes > 0) chk("accepts per frame", 32'(acc_cnt), 32'd1);
                strobes++;
                acc_cnt = 0;
            end
        end
        if (strobes < 4) expire("streaming frames");
        src_valid = 1'b0;

        // disable keeps a full hold; its sample is the first frame after re-enable
        offer(32'h1357_9BDF);
        enable = 1'b0;
        repeat (20) cycle();
        chk("disabled ready", 32'(if_a.s_ready), 32'h0);
        chk("disabled bclk",  32'(bclk_a),       32'h0);
        enable = 1'b1;
        run_frame(wa, wb);
        chk("reenable frame a", wa, 32'h1357_9BDF);
        chk("reenable frame b", wb, 32'h1357_9BDF);

        // randomized traffic against the model
        off_cnt = 0;
        for (int i = 0; i < 12000; i++) begin
            src_valid    = ($urandom_range(0, 2) != 0);
            src_l        = 16'($urandom);
            src_r        = 16'($urandom);
            underrun_clr = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 900) == 0) mute = !mute;
            if (off_cnt > 0) begin
                off_cnt--;
                if (off_cnt == 0) enable = 1'b1;
            end else if ($urandom_range(0, 3000) == 0) begin
                enable  = 1'b0;
                off_cnt = int'($urandom_range(1, 40));
            end
            cycle();
        end
        src_valid    = 1'b0;
        underrun_clr = 1'b0;
        mute         = 1'b0;
        enable       = 1'b1;
        offer(32'hA5A5_5A5A);
        for (int k = 0; k < 300; k++) cycle();

        // asynchronous reset mid-frame
        #2 reset_n = 1'b0;
        #1;
        chk("async bclk a",  32'(bclk_a),       32'h0);
        chk("async lrck a",  32'(lrck_a),       32'h0);
        chk("async din a",   32'(din_a),        32'h0);
        chk("async fs a",    32'(fs_a),         32'h0);
        chk("async under a", 32'(und_a),        32'h0);
        chk("async ready a", 32'(if_a.s_ready), 32'h1);
        chk("async bclk b",  32'(bclk_b),       32'h0);
        chk("async ready b", 32'(if_b.s_ready), 32'h1);
        repeat (2) cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 200; k++) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
